// File: rtl/seq_mon_pkg.sv
// Shared types and default sizing for the sequence event monitor.
// The record struct matches the default field widths.
package seq_mon_pkg;
  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] idx;
    logic [LEN_W_DEF-1:0] len;
  } rec_t;
endpackage

// File: rtl/seq_rec_fifo.sv
// First-word-fall-through record FIFO. The pointers carry an extra wrap bit.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module seq_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push_s, do_pop_s;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_pop_s  = pop && !empty && !clr;
    do_push_s = push && !clr && (!full || do_pop_s);
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push_s) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is cleared on reset so the head fields read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/seq_event_monitor.sv
// Turns each high run of the detector level into an {index, length} record.
// It also keeps a running event count and a sticky drop flag.
module seq_event_monitor
  import seq_mon_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   det_in,
  input  logic                   clr,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [CNT_W-1:0]       rec_idx,
  output logic [LEN_W-1:0]       rec_len,
  output logic [CNT_W-1:0]       evt_count,
  output logic                   drop_flag,
  output logic [$clog2(DEPTH):0] fifo_level
);
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   cur_idx_q, cur_idx_d;
  logic [CNT_W-1:0]   evt_count_q, evt_count_d;
  logic               drop_q, drop_d;
  logic               push_s, pop_s, empty_s, full_s;
  logic [CNT_W+LEN_W-1:0] dout_s;

  assign push_s     = (state_q == RUN) && !det_in;
  assign pop_s      = !empty_s && rec_ready;
  assign rec_valid  = !empty_s;
  assign rec_idx    = dout_s[LEN_W +: CNT_W];
  assign rec_len    = dout_s[LEN_W-1:0];
  assign evt_count  = evt_count_q;
  assign drop_flag  = drop_q;

  seq_rec_fifo #(.DEPTH(DEPTH), .W(CNT_W + LEN_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clr   (clr),
    .din   ({cur_idx_q, run_len_q}),
    .dout  (dout_s),
    .empty (empty_s),
    .full  (full_s),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    cur_idx_d   = cur_idx_q;
    evt_count_d = evt_count_q;
    drop_d      = drop_q;
    if (clr) begin
      state_d     = IDLE;
      run_len_d   = '0;
      cur_idx_d   = '0;
      evt_count_d = '0;
      drop_d      = 1'b0;
    end else begin
      // A record is lost only when the FIFO is full and no pop frees a slot.
      if (push_s && full_s && !pop_s) drop_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (det_in) begin
            state_d     = RUN;
            run_len_d   = {{(LEN_W-1){1'b0}}, 1'b1};
            cur_idx_d   = evt_count_q;
            evt_count_d = evt_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (det_in) begin
            if (run_len_q != {LEN_W{1'b1}}) run_len_d = run_len_q + {{(LEN_W-1){1'b0}}, 1'b1};
            else run_len_d = run_len_q;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_len_q   <= '0;
      cur_idx_q   <= '0;
      evt_count_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      cur_idx_q   <= cur_idx_d;
      evt_count_q <= evt_count_d;
      drop_q      <= drop_d;
    end
  end
endmodule

// File: tb/tb_seq_event_monitor.sv
// Self-checking bench: a reference model queues expected records as stimulus is driven,
// and a negedge scoreboard compares each head record as the DUT presents and pops it.
module tb_seq_event_monitor;
  import seq_mon_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b1, det_in = 1'b0, clr = 1'b0, rec_ready = 1'b0;
  logic       rec_valid, drop_flag;
  logic [7:0] rec_idx, rec_len, evt_count;
  logic [2:0] fifo_level;

  rec_t       q[$];
  logic       m_run = 1'b0, m_drop = 1'b0;
  logic [7:0] m_len = 8'd0, m_idx = 8'd0, m_cnt = 8'd0;
  int         n_cmp = 0, n_err = 0, n_pops = 0;

  seq_event_monitor #(.LEN_W(8), .CNT_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_idx(rec_idx), .rec_len(rec_len),
    .evt_count(evt_count), .drop_flag(drop_flag), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_run = 1'b0; m_drop = 1'b0; m_len = 8'd0; m_idx = 8'd0; m_cnt = 8'd0;
  endtask

  // Drive one clock of stimulus; the expected record is queued once the edge has passed.
  task automatic cycle(input logic d, input logic r, input logic c);
    logic pop, full, push;
    rec_t rec;
    det_in = d; rec_ready = r; clr = c;
    pop  = r && (q.size() != 0);
    full = (q.size() == DEPTH);
    push = m_run && !d;
    rec.idx = m_idx; rec.len = m_len;
    @(posedge clk); #1;
    if (c) begin
      model_reset();
    end else begin
      if (push) begin
        if (full && !pop) m_drop = 1'b1;
        else q.push_back(rec);
      end
      if (d && !m_run) begin
        m_run = 1'b1; m_len = 8'd1; m_idx = m_cnt; m_cnt = m_cnt + 8'd1;
      end else if (d) begin
        if (m_len != 8'hFF) m_len = m_len + 8'd1;
      end else begin
        m_run = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; det_in = 1'b0; clr = 1'b0; rec_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard: compare the presented head against the queue and pop on a handshake.
  always @(negedge clk) begin
    n_cmp++; if (rec_valid !== (q.size() != 0)) begin n_err++; $display("FAIL sb_valid got %0b exp %0b", rec_valid, q.size() != 0); end
    n_cmp++; if (fifo_level !== 3'(q.size())) begin n_err++; $display("FAIL sb_level got %0d exp %0d", fifo_level, q.size()); end
    n_cmp++; if (evt_count !== m_cnt) begin n_err++; $display("FAIL sb_evt got %0d exp %0d", evt_count, m_cnt); end
    n_cmp++; if (drop_flag !== m_drop) begin n_err++; $display("FAIL sb_drop got %0b exp %0b", drop_flag, m_drop); end
    if (q.size() != 0) begin
      n_cmp++; if (rec_idx !== q[0].idx) begin n_err++; $display("FAIL sb_idx got %0d exp %0d", rec_idx, q[0].idx); end
      n_cmp++; if (rec_len !== q[0].len) begin n_err++; $display("FAIL sb_len got %0d exp %0d", rec_len, q[0].len); end
      if (rec_ready && !clr && !rst) begin
        void'(q.pop_front());
        n_pops++;
      end
    end
  end

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", rec_valid); end
    n_cmp++; if (rec_idx !== 8'd0 || rec_len !== 8'd0) begin n_err++; $display("FAIL reset_rec got %0d/%0d exp 0/0", rec_idx, rec_len); end
    n_cmp++; if (evt_count !== 8'd0 || drop_flag !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_misc got %0d/%0b/%0d exp 0/0/0", evt_count, drop_flag, fifo_level); end
  endtask

  task automatic test_single_run();
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (rec_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b exp 1", rec_valid); end
    n_cmp++; if (rec_idx !== 8'd0 || rec_len !== 8'd3) begin n_err++; $display("FAIL single_rec got %0d/%0d exp 0/3", rec_idx, rec_len); end
    n_cmp++; if (evt_count !== 8'd1 || fifo_level !== 3'd1) begin n_err++; $display("FAIL single_cnt got %0d/%0d exp 1/1", evt_count, fifo_level); end
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset();
    p0 = n_pops;
    cycle(1'b1, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (rec_idx !== 8'd1 || rec_len !== 8'd2 || rec_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second got %0d/%0d/%0b exp 1/2/1", rec_idx, rec_len, rec_valid); end
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (evt_count !== 8'd2 || fifo_level !== 3'd0) begin n_err++; $display("FAIL b2b_end got %0d/%0d exp 2/0", evt_count, fifo_level); end
    n_cmp++; if (n_pops - p0 !== 2) begin n_err++; $display("FAIL b2b_pops got %0d exp 2", n_pops - p0); end
  endtask

  task automatic test_full_drop();
    int p0;
    do_reset();
    repeat (5) begin cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0); end
    n_cmp++; if (fifo_level !== 3'd4 || drop_flag !== 1'b1) begin n_err++; $display("FAIL full_state got %0d/%0b exp 4/1", fifo_level, drop_flag); end
    n_cmp++; if (rec_idx !== 8'd0) begin n_err++; $display("FAIL full_head got %0d exp 0", rec_idx); end
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (fifo_level !== 3'd4 || rec_idx !== 8'd1) begin n_err++; $display("FAIL pushpop_full got %0d/%0d exp 4/1", fifo_level, rec_idx); end
    p0 = n_pops;
    repeat (5) cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (fifo_level !== 3'd0 || n_pops - p0 !== 4) begin n_err++; $display("FAIL full_drain got %0d/%0d exp 0/4", fifo_level, n_pops - p0); end
  endtask

  task automatic test_sat_wrap();
    do_reset();
    repeat (300) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (rec_len !== 8'd255 || rec_idx !== 8'd0) begin n_err++; $display("FAIL sat_len got %0d/%0d exp 255/0", rec_len, rec_idx); end
    for (int i = 0; i < 255; i++) begin cycle(1'b1, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0); end
    cycle(1'b1, 1'b1, 1'b0); cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL wrap_cnt got %0d exp 1", evt_count); end
    n_cmp++; if (rec_idx !== 8'd0 || rec_len !== 8'd1 || fifo_level !== 3'd1) begin n_err++; $display("FAIL wrap_last got %0d/%0d/%0d exp 0/1/1", rec_idx, rec_len, fifo_level); end
  endtask

  task automatic test_clear_mid_run();
    do_reset();
    repeat (5) begin cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0); end
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++; if (fifo_level !== 3'd0 || rec_valid !== 1'b0) begin n_err++; $display("FAIL clr_fifo got %0d/%0b exp 0/0", fifo_level, rec_valid); end
    n_cmp++; if (drop_flag !== 1'b0 || evt_count !== 8'd0) begin n_err++; $display("FAIL clr_flags got %0b/%0d exp 0/0", drop_flag, evt_count); end
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (rec_idx !== 8'd0 || rec_len !== 8'd2 || evt_count !== 8'd1 || fifo_level !== 3'd1) begin n_err++; $display("FAIL clr_rec got %0d/%0d/%0d/%0d exp 0/2/1/1", rec_idx, rec_len, evt_count, fifo_level); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) begin cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0); end
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1; det_in = 1'b0;
    #1;
    n_cmp++; if (rec_valid !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL arst_fifo got %0b/%0d exp 0/0", rec_valid, fifo_level); end
    n_cmp++; if (rec_idx !== 8'd0 || rec_len !== 8'd0) begin n_err++; $display("FAIL arst_rec got %0d/%0d exp 0/0", rec_idx, rec_len); end
    n_cmp++; if (evt_count !== 8'd0 || drop_flag !== 1'b0) begin n_err++; $display("FAIL arst_cnt got %0d/%0b exp 0/0", evt_count, drop_flag); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (rec_idx !== 8'd0 || rec_len !== 8'd1 || evt_count !== 8'd1) begin n_err++; $display("FAIL arst_after got %0d/%0d/%0d exp 0/1/1", rec_idx, rec_len, evt_count); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_full_drop();
    test_sat_wrap();
    test_clear_mid_run();
    test_async_reset();
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
